// File: rtl/rtc_alarm_unit.sv
// rtc_alarm_unit: alarm time register, time/alarm compare and ringing controller
// for the real-time clock board. Consumes the BCD digit counters and the 1 Hz tick.
//
// Optional feature macro: RTC_ALARM_SNOOZE_EN (snooze input, SNOOZE state and
// snooze counters). Undefined by default: snooze is ignored, state 11 unreachable.
//
// Ports:
//   clk        system clock
//   aclr       asynchronous active-low reset
//   tick       1-clk pulse once per second
//   time_bcd   running time {h1,h0,m1,m0,s1,s0}, 4-bit BCD digits
//   set_val    binary load value from switches
//   set_sel    load target: 0 seconds, 1 minutes, 2 hours, 3 reserved
//   set_stb    1-clk load strobe
//   arm_en     level, alarm enabled
//   stop       1-clk pulse, silence the alarm
//   snooze     1-clk pulse, postpone the alarm
//   alarm_bcd  stored alarm time, same packing as time_bcd
//   state      00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE
//   ringing    high while in RINGING
//   buzz       1 Hz square wave while ringing
//   set_err    1-clk pulse on a rejected load
module rtc_alarm_unit #(
    parameter int unsigned RING_SECONDS   = 30,
    parameter int unsigned SNOOZE_SECONDS = 60,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        tick,
    input  logic [23:0] time_bcd,
    input  logic [7:0]  set_val,
    input  logic [1:0]  set_sel,
    input  logic        set_stb,
    input  logic        arm_en,
    input  logic        stop,
    input  logic        snooze,
    output logic [23:0] alarm_bcd,
    output logic [1:0]  state,
    output logic        ringing,
    output logic        buzz,
    output logic        set_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_RINGING = 2'b10,
        S_SNOOZE  = 2'b11
    } state_t;

    state_t             state_q, state_nx;
    logic [CNT_W-1:0]   ring_cnt_q, ring_cnt_nx;
    logic               buzz_nx, ringing_nx;
    logic [23:0]        alarm_nx;
    logic               set_err_nx;
    logic               match, match_prev, trigger;
    logic               ring_done, snooze_ok, snooze_done;
    logic [3:0]         load_tens, load_units;

`ifdef RTC_ALARM_SNOOZE_EN
    logic [CNT_W-1:0]   snooze_cnt_q, snooze_cnt_nx;
    logic [CNT_W-1:0]   snooze_num_q, snooze_num_nx;

    assign snooze_ok   = snooze && (snooze_num_q < CNT_W'(MAX_SNOOZE));
    assign snooze_done = (snooze_cnt_q == CNT_W'(SNOOZE_SECONDS - 1));
`else
    logic               unused_snooze;
    logic [15:0]        unused_cfg;

    assign unused_snooze = snooze;
    assign unused_cfg    = {8'(SNOOZE_SECONDS), 8'(MAX_SNOOZE)};
    assign snooze_ok     = 1'b0;
    assign snooze_done   = 1'b0;
`endif

    assign state     = state_q;
    assign match     = (time_bcd == alarm_bcd);
    // Rising edge of equality only, so arming onto an already-equal time stays quiet.
    assign trigger   = match && !match_prev;
    assign ring_done = (ring_cnt_q == CNT_W'(RING_SECONDS - 1));

    // Alarm field load with range check; tens digit of a legal value fits in 4 bits.
    always_comb begin : load_logic
        alarm_nx   = alarm_bcd;
        set_err_nx = 1'b0;
        load_tens  = 4'(set_val / 8'd10);
        load_units = 4'(set_val % 8'd10);
        if (set_stb) begin
            case (set_sel)
                2'd0: if (set_val <= 8'd59) alarm_nx[7:0]   = {load_tens, load_units};
                      else                  set_err_nx      = 1'b1;
                2'd1: if (set_val <= 8'd59) alarm_nx[15:8]  = {load_tens, load_units};
                      else                  set_err_nx      = 1'b1;
                2'd2: if (set_val <= 8'd23) alarm_nx[23:16] = {load_tens, load_units};
                      else                  set_err_nx      = 1'b1;
                default: set_err_nx = 1'b1;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge aclr) begin : regs
        if (!aclr) begin
            state_q      <= S_IDLE;
            ring_cnt_q   <= '0;
            buzz         <= 1'b0;
            ringing      <= 1'b0;
            alarm_bcd    <= '0;
            set_err      <= 1'b0;
            match_prev   <= 1'b0;
`ifdef RTC_ALARM_SNOOZE_EN
            snooze_cnt_q <= '0;
            snooze_num_q <= '0;
`endif
        end else begin
            state_q      <= state_nx;
            ring_cnt_q   <= ring_cnt_nx;
            buzz         <= buzz_nx;
            ringing      <= ringing_nx;
            alarm_bcd    <= alarm_nx;
            set_err      <= set_err_nx;
            match_prev   <= match;
`ifdef RTC_ALARM_SNOOZE_EN
            snooze_cnt_q <= snooze_cnt_nx;
            snooze_num_q <= snooze_num_nx;
`endif
        end
    end

    // Next state; priority arm_en=0 > stop > snooze > tick timeout > trigger.
    always_comb begin : next_state
        state_nx = state_q;
        if (!arm_en) begin
            state_nx = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_nx = S_ARMED;
                S_ARMED:   if (trigger) state_nx = S_RINGING;
                S_RINGING: begin
                    if (stop)                   state_nx = S_ARMED;
                    else if (snooze_ok)         state_nx = S_SNOOZE;
                    else if (tick && ring_done) state_nx = S_ARMED;
                end
`ifdef RTC_ALARM_SNOOZE_EN
                S_SNOOZE: begin
                    if (stop)                     state_nx = S_ARMED;
                    else if (tick && snooze_done) state_nx = S_RINGING;
                end
`endif
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    // Counters and buzzer; counters only clear on entry, so disarm leaves them holding.
    always_comb begin : output_logic
        ring_cnt_nx = ring_cnt_q;
        buzz_nx     = buzz;
        ringing_nx  = (state_nx == S_RINGING);
`ifdef RTC_ALARM_SNOOZE_EN
        snooze_cnt_nx = snooze_cnt_q;
        snooze_num_nx = snooze_num_q;
`endif
        if (!arm_en) begin
            buzz_nx = 1'b0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (trigger) begin
                        ring_cnt_nx = '0;
                        buzz_nx     = 1'b1;
`ifdef RTC_ALARM_SNOOZE_EN
                        snooze_num_nx = '0;
`endif
                    end
                end
                S_RINGING: begin
                    if (stop) begin
                        buzz_nx = 1'b0;
                    end else if (snooze_ok) begin
                        buzz_nx = 1'b0;
`ifdef RTC_ALARM_SNOOZE_EN
                        snooze_cnt_nx = '0;
                        snooze_num_nx = snooze_num_q + CNT_W'(1);
`endif
                    end else if (tick) begin
                        ring_cnt_nx = ring_cnt_q + CNT_W'(1);
                        buzz_nx     = ring_done ? 1'b0 : !buzz;
                    end
                end
`ifdef RTC_ALARM_SNOOZE_EN
                S_SNOOZE: begin
                    if (!stop && tick) begin
                        snooze_cnt_nx = snooze_cnt_q + CNT_W'(1);
                        if (snooze_done) begin
                            ring_cnt_nx = '0;
                            buzz_nx     = 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rtc_alarm_unit.md
Name: rtc_alarm_unit

Overview:
- Downstream consumer of the BCD digit counters of the real-time clock board.
- Holds an alarm time loaded from the 8-bit switch bank and compares it against the running clock digits.
- Drives a ringing/buzzer output with auto-timeout and optional snooze.
- Sits between the digit-counter chain and the LEDR/indicator outputs; the 1 Hz tick comes from the existing clock divider.

Parameters:
- RING_SECONDS, 30, ticks spent in RINGING before auto-return to ARMED (range 2..255).
- SNOOZE_SECONDS, 60, ticks spent in SNOOZE before ringing again (range 2..255).
- MAX_SNOOZE, 3, snoozes accepted per alarm episode; further snooze pulses are ignored.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- aclr  in  1  asynchronous active-low reset.
- tick  in  1  one-clk-wide pulse, once per second.
- time_bcd  in  24  running time {h1,h0,m1,m0,s1,s0}, 4-bit BCD each.
- set_val  in  8  binary value from switches, 0..255.
- set_sel  in  2  target field: 0 = seconds, 1 = minutes, 2 = hours, 3 = reserved.
- set_stb  in  1  one-clk load strobe.
- arm_en  in  1  level; 1 = alarm enabled.
- stop  in  1  one-clk pulse; silence the alarm.
- snooze  in  1  one-clk pulse; postpone the alarm.
- alarm_bcd  out  24  stored alarm time, same packing as time_bcd.
- state  out  2  00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE.
- ringing  out  1  state==RINGING.
- buzz  out  1  1 Hz square wave while ringing.
- set_err  out  1  one-clk pulse on a rejected load.

Behaviour:
- Reset (aclr low, async): alarm_bcd=0 (00:00:00); state=IDLE; buzz=0; set_err=0; ring_cnt=snooze_cnt=snooze_num=0; match_prev=0.
- Load on set_stb:
  - Limits are 59 for sel 0/1 and 23 for sel 2.
  - If set_val ≤ limit: field units=set_val%10 and tens=set_val/10 are registered; visible on alarm_bcd the next cycle.
  - Else, or sel=3: no change and set_err=1 for one cycle.
  - A load never changes state.
- Match:
  - match = (time_bcd==alarm_bcd), registered into match_prev every cycle in every state.
  - trigger = match & ~match_prev (rising edge only).
  - Arming while the times are already equal does not ring.
- Transitions, evaluated each clk in priority order arm_en=0 > stop > snooze > tick timeout > trigger:
  - IDLE: arm_en=1 → ARMED.
  - ARMED: trigger → RINGING; ring_cnt=0, snooze_num=0, buzz=1.
  - RINGING:
    - stop → ARMED.
    - snooze with snooze_num<MAX_SNOOZE → SNOOZE; snooze_cnt=0, snooze_num++, buzz=0.
    - On tick: ring_cnt++ and buzz toggles.
    - tick with ring_cnt==RING_SECONDS-1 → ARMED, buzz=0.
  - SNOOZE:
    - stop → ARMED.
    - On tick: snooze_cnt++.
    - tick with snooze_cnt==SNOOZE_SECONDS-1 → RINGING; ring_cnt=0, buzz=1.
  - Any state with arm_en=0 → IDLE, buzz=0. Counters hold their values; they are cleared on the next entry.
- A trigger arriving in RINGING or SNOOZE is ignored.
- A snooze pulse in ARMED or IDLE is ignored.
- Latency:
  - ringing rises 1 clk after the cycle in which time_bcd first equals alarm_bcd.
  - stop takes effect on the next clk edge.
- Counters are 8-bit and never wrap, because the terminal compare fires first.

Optional Feature:
- Macro: RTC_ALARM_SNOOZE_EN.
- Defined: snooze input, SNOOZE state, snooze_cnt and snooze_num are implemented as above.
- Undefined: snooze is ignored, state 11 is unreachable, and snooze_cnt/snooze_num logic is not synthesised. SNOOZE_SECONDS and MAX_SNOOZE remain legal but unused.

Test Plan:
- Reset mid-RINGING → alarm_bcd=0, state=00, buzz=0 immediately, without waiting for clk.
- Loads:
  - set_sel=1, set_val=45, set_stb → alarm_bcd[15:8]=4'h4,4'h5.
  - set_val=60 with sel=0 → set_err pulse 1 clk, alarm_bcd unchanged.
  - set_val=24 with sel=2 → set_err pulse 1 clk, alarm_bcd unchanged.
- Alarm 00:01:30, arm_en=1, time_bcd steps 00:01:29 → 00:01:30 → ringing=1 next clk. With no stop, exactly 30 ticks later → state=01, buzz=0. Buzz toggles on each of those ticks.
- Ringing, snooze pulse, then 60 ticks → RINGING again. A 4th snooze pulse within one episode is ignored and state stays 10 (macro defined).
- Same snooze pulse with macro undefined → state stays 10.
- Ringing with stop and snooze in the same clk → ARMED.
- arm_en dropped while in SNOOZE → IDLE.
- time_bcd already equals alarm_bcd when arm_en rises → no ringing. The next equality edge (e.g. 24 h later, or after forcing time_bcd away and back) → rings.
